// File: rtl/stream_mux_nto1_pkg.sv
// Shared types and helpers for the N:1 framed-stream selector.
// Holds the selector FSM state type and the channel-slice extraction function.
package zigbee_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        SWITCH = 2'd2
    } mux_state_t;

    localparam int CH_BUS_MAX = 256;
    localparam int CH_W_MAX   = 32;

    // Returns the width-bit field at position idx of a packed channel bus, zero above width.
    function automatic logic [CH_W_MAX-1:0] ch_slice(
        input logic [CH_BUS_MAX-1:0] bus,
        input int                    idx,
        input int                    width
    );
        logic [CH_BUS_MAX-1:0] sh_s;
        logic [CH_W_MAX-1:0]   res_s;
        sh_s  = bus >> (idx * width);
        res_s = sh_s[CH_W_MAX-1:0];
        for (int b = 0; b < CH_W_MAX; b++) begin
            if (b >= width) begin
                res_s[b] = 1'b0;
            end
        end
        return res_s;
    endfunction

endpackage

// File: rtl/stream_mux_nto1_if.sv
// Handshake bundle between the upstream channel generators, the selector and the modulator.
// The master side drives the channel inputs and downstream ready; the slave side is the selector.
interface stream_mux_nto1_if #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH*WIDTH-1:0] inData;
    logic [N_CH-1:0]       inValid;
    logic [N_CH-1:0]       inLast;
    logic [N_CH-1:0]       outReady;
    logic [SEL_W-1:0]      inSel;
    logic                  inSelReq;
    logic [WIDTH-1:0]      outData;
    logic                  outValid;
    logic                  outLast;
    logic                  inReady;
    logic [SEL_W-1:0]      outActiveCh;
    logic                  outSelErr;

    modport master (
        output inData, inValid, inLast, inSel, inSelReq, inReady,
        input  outReady, outData, outValid, outLast, outActiveCh, outSelErr
    );

    modport slave (
        input  inData, inValid, inLast, inSel, inSelReq, inReady,
        output outReady, outData, outValid, outLast, outActiveCh, outSelErr
    );

endinterface

// File: rtl/stream_mux_nto1_out_reg.sv
// Single valid/ready register stage carrying one data beat plus its end-of-frame flag.
// Data is only captured with a real beat so a bubble never disturbs the held value.
module stream_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             down_ready,
    output logic             load_en,
    output logic [WIDTH-1:0] q_data,
    output logic             q_valid,
    output logic             q_last
);

    logic [WIDTH-1:0] data_r;
    logic             valid_r;
    logic             last_r;

    assign load_en = !valid_r || down_ready;

    // Output beat register: refills whenever empty or being drained downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (load_en) begin
            valid_r <= load_valid;
            last_r  <= load_valid && load_last;
            if (load_valid) begin
                data_r <= load_data;
            end
        end
    end

    assign q_data  = data_r;
    assign q_valid = valid_r;
    assign q_last  = last_r;

endmodule

// File: rtl/stream_mux_nto1.sv
// N:1 framed-stream selector: routes one valid/ready channel to a registered output and
// defers channel switch requests to frame boundaries.
module stream_mux_nto1
    import zigbee_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4
) (
    input  logic              inClk,
    input  logic              inReset,
    stream_mux_nto1_if.slave  bus
);

    localparam int               SEL_W  = $clog2(N_CH);
    localparam logic [SEL_W:0]   N_CH_L = (SEL_W+1)'(N_CH);

    mux_state_t       state_r;
    mux_state_t       state_nxt_s;
    logic [SEL_W-1:0] active_ch_r;
    logic [SEL_W-1:0] pend_sel_r;
    logic             pend_valid_r;
    logic             sel_err_r;

    logic             sel_ok_s;
    logic             sel_err_s;
    logic [SEL_W-1:0] eff_ch_s;
    logic             ready_ok_s;
    logic             load_en_s;
    logic             accept_s;
    logic [WIDTH-1:0] beat_data_s;
    logic             beat_valid_s;
    logic             beat_last_s;

    assign sel_err_s = bus.inSelReq && ({1'b0, bus.inSel} >= N_CH_L);
    assign sel_ok_s  = bus.inSelReq && ({1'b0, bus.inSel} <  N_CH_L);
    // A request arriving during the switch cycle is judged against the channel being switched to.
    assign eff_ch_s  = (state_r == SWITCH) ? pend_sel_r : active_ch_r;

    // Picks the active channel's beat; the other channels never reach the datapath.
    always_comb begin
        beat_data_s  = WIDTH'(ch_slice(CH_BUS_MAX'(bus.inData), int'(active_ch_r), WIDTH));
        beat_valid_s = |ch_slice(CH_BUS_MAX'(bus.inValid), int'(active_ch_r), 1);
        beat_last_s  = |ch_slice(CH_BUS_MAX'(bus.inLast), int'(active_ch_r), 1);
    end

    assign ready_ok_s = !inReset && (state_r != SWITCH)
                        && !(state_r == IDLE && pend_valid_r) && load_en_s;
    assign accept_s   = beat_valid_s && ready_ok_s;

    for (genvar c = 0; c < N_CH; c++) begin : g_ready
        assign bus.outReady[c] = ready_ok_s && (active_ch_r == SEL_W'(c));
    end

    // Frame tracking: a pending switch is only honoured from IDLE, i.e. between frames.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pend_valid_r) begin
                    state_nxt_s = SWITCH;
                end else if (accept_s && !beat_last_s) begin
                    state_nxt_s = LOCKED;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCKED: begin
                if (accept_s && beat_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            SWITCH:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, active channel, pending request latch and select-error pulse.
    always_ff @(posedge inClk) begin
        if (inReset) begin
            state_r      <= IDLE;
            active_ch_r  <= {SEL_W{1'b0}};
            pend_sel_r   <= {SEL_W{1'b0}};
            pend_valid_r <= 1'b0;
            sel_err_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            sel_err_r <= sel_err_s;
            if (state_r == SWITCH) begin
                active_ch_r <= pend_sel_r;
            end
            if (sel_ok_s) begin
                pend_sel_r   <= bus.inSel;
                pend_valid_r <= (bus.inSel != eff_ch_s);
            end else if (state_r == SWITCH) begin
                pend_valid_r <= 1'b0;
            end
        end
    end

    stream_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk        (inClk),
        .rst        (inReset),
        .load_valid (accept_s),
        .load_data  (beat_data_s),
        .load_last  (beat_last_s),
        .down_ready (bus.inReady),
        .load_en    (load_en_s),
        .q_data     (bus.outData),
        .q_valid    (bus.outValid),
        .q_last     (bus.outLast)
    );

    assign bus.outActiveCh = active_ch_r;
    assign bus.outSelErr   = sel_err_r;

endmodule
